// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: count sizing, leading-ones count
// and lane-index types.
package fifo_pkg;

  localparam int MaxLanes = 32;

  typedef logic [$clog2(MaxLanes)-1:0] lane_idx_t;

  // Occupancy counter width that can hold every value from 0 to depth.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Length of the unbroken run of ones that starts at bit 0.
  // Only the lowest len bits are examined.
  function automatic int lead_ones_cnt(input logic [MaxLanes-1:0] vec, input int len);
    int  n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MaxLanes; i++) begin
      if (i < len && run) begin
        if (vec[i]) n++;
        else        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/prefix_count.sv
// Leading-ones counter: how many lanes, starting at lane 0, are accepted
// before the first lane that is not.
module prefix_count
  import fifo_pkg::*;
#(
  parameter int N    = 2,
  parameter int CntW = $clog2(N + 1)
) (
  input  logic [N-1:0]    vec,
  output logic [CntW-1:0] cnt
);

  if (N < 1 || N > MaxLanes) begin : g_bad_n
    $error("prefix_count: N must be in 1..%0d", MaxLanes);
  end

  // Zero-extend into the package helper's fixed width and truncate the result.
  always_comb begin
    cnt = CntW'(lead_ones_cnt(MaxLanes'(vec), N));
  end

endmodule

// File: rtl/fifo_multi_lane.sv
// Multi-lane first-word-fall-through FIFO: up to Lanes pushes and pops per
// cycle, strict ordering, synchronous flush, occupancy count and almost-full.
module fifo_multi_lane
  import fifo_pkg::*;
#(
  parameter int DepthLog2        = 3,
  parameter int Width            = 32,
  parameter int Lanes            = 2,
  parameter int AlmostFullThresh = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [Lanes-1:0]       wr_valid_i,
  input  logic [Lanes*Width-1:0] wr_data_i,
  output logic [Lanes-1:0]       wr_ready_o,
  output logic [Lanes-1:0]       rd_valid_o,
  output logic [Lanes*Width-1:0] rd_data_o,
  input  logic [Lanes-1:0]       rd_ready_i,
  output logic [DepthLog2:0]     count_o,
  output logic                   almost_full_o
);

  localparam int Depth = 1 << DepthLog2;
  localparam int CntW  = count_width(Depth);
  localparam int PcW   = $clog2(Lanes + 1);

  if (DepthLog2 < 1) begin : g_bad_depth
    $error("fifo_multi_lane: DepthLog2 must be >= 1");
  end
  if (Lanes < 1 || Lanes > Depth) begin : g_bad_lanes
    $error("fifo_multi_lane: Lanes must be in 1..Depth");
  end
  if (AlmostFullThresh < 1 || AlmostFullThresh > Depth) begin : g_bad_thresh
    $error("fifo_multi_lane: AlmostFullThresh must be in 1..Depth");
  end
  if (CntW != DepthLog2 + 1) begin : g_bad_cntw
    $error("fifo_multi_lane: count width mismatch");
  end

  typedef logic [DepthLog2-1:0] ptr_t;

  ptr_t              rd_ptr_q;
  ptr_t              wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [Width-1:0]  mem [Depth];

  logic [Lanes-1:0]  push_vec;
  logic [Lanes-1:0]  pop_vec;
  logic [PcW-1:0]    n_push;
  logic [PcW-1:0]    n_pop;

  // Handshake outputs depend only on the registered count, never on inputs.
  always_comb begin
    wr_ready_o = '0;
    rd_valid_o = '0;
    for (int k = 0; k < Lanes; k++) begin
      wr_ready_o[k] = (Depth - int'(count_q)) > k;
      rd_valid_o[k] = int'(count_q) > k;
    end
    almost_full_o = int'(count_q) >= AlmostFullThresh;
    count_o       = count_q;
  end

  // Fall-through read: lane k shows the entry k slots past the head, wrapping.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < Lanes; k++) begin
      rd_data_o[k*Width +: Width] = mem[rd_ptr_q + ptr_t'(k)];
    end
  end

  assign push_vec = wr_valid_i & wr_ready_o;
  assign pop_vec  = rd_valid_o & rd_ready_i;

  prefix_count #(.N(Lanes), .CntW(PcW)) u_push_cnt (
    .vec (push_vec),
    .cnt (n_push)
  );

  prefix_count #(.N(Lanes), .CntW(PcW)) u_pop_cnt (
    .vec (pop_vec),
    .cnt (n_pop)
  );

  // Pointer and occupancy update; flush wins over any push or pop that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + ptr_t'(n_push);
      rd_ptr_q <= rd_ptr_q + ptr_t'(n_pop);
      count_q  <= count_q + CntW'(n_push) - CntW'(n_pop);
    end
  end

  // Storage writes for the accepted prefix of lanes; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int k = 0; k < Lanes; k++) begin
        if (k < int'(n_push)) begin
          mem[wr_ptr_q + ptr_t'(k)] <= wr_data_i[k*Width +: Width];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_multi_lane.sv
// Directed testbench for fifo_multi_lane (Depth 8, Width 32, Lanes 2, threshold 6).
module tb_fifo_multi_lane;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic [1:0]  wr_valid_i;
  logic [63:0] wr_data_i;
  logic [1:0]  wr_ready_o;
  logic [1:0]  rd_valid_o;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_ready_i;
  logic [3:0]  count_o;
  logic        almost_full_o;

  int n_cmp;
  int n_fail;

  fifo_multi_lane #(
    .DepthLog2        (3),
    .Width            (32),
    .Lanes            (2),
    .AlmostFullThresh (6)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .wr_valid_i    (wr_valid_i),
    .wr_data_i     (wr_data_i),
    .wr_ready_o    (wr_ready_o),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_ready_i    (rd_ready_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Drive one cycle's worth of inputs.
  task automatic apply_stimulus(input logic fl, input logic [1:0] wv,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic [1:0] rr);
    flush_i    = fl;
    wr_valid_i = wv;
    wr_data_i  = {d1, d0};
    rd_ready_i = rr;
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    rst_i = 1'b1;
    #2;
    n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (rd_valid_o !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rd_valid got %b want 00", rd_valid_o); end
    n_cmp++; if (wr_ready_o !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_wr_ready got %b want 11", wr_ready_o); end
    n_cmp++; if (almost_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_af got %b want 0", almost_full_o); end
    tick;
    rst_i = 1'b0;
    tick;
  endtask

  task automatic test_first_push;
    apply_stimulus(1'b0, 2'b11, 32'hA1, 32'hA0, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd2) begin n_fail++; $display("[TB] FAIL push_count got %0d want 2", count_o); end
    n_cmp++; if (rd_valid_o !== 2'b11) begin n_fail++; $display("[TB] FAIL push_rd_valid got %b want 11", rd_valid_o); end
    n_cmp++; if (rd_data_o[31:0] !== 32'hA0) begin n_fail++; $display("[TB] FAIL push_lane0 got %0h want a0", rd_data_o[31:0]); end
    n_cmp++; if (rd_data_o[63:32] !== 32'hA1) begin n_fail++; $display("[TB] FAIL push_lane1 got %0h want a1", rd_data_o[63:32]); end
    n_cmp++; if (almost_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL push_af got %b want 0", almost_full_o); end
  endtask

  task automatic test_fill;
    logic [3:0] exp_cnt [4];
    logic       exp_af  [4];
    exp_cnt = '{4'd2, 4'd4, 4'd6, 4'd8};
    exp_af  = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    tick;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 2'b11, 32'(2*i+1), 32'(2*i), 2'b00);
      tick;
      n_cmp++; if (count_o !== exp_cnt[i]) begin n_fail++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count_o, exp_cnt[i]); end
      n_cmp++; if (almost_full_o !== exp_af[i]) begin n_fail++; $display("[TB] FAIL fill_af[%0d] got %b want %b", i, almost_full_o, exp_af[i]); end
    end
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (wr_ready_o !== 2'b00) begin n_fail++; $display("[TB] FAIL full_wr_ready got %b want 00", wr_ready_o); end
    // Pop one entry: value 0 leaves, head becomes 1.
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd7) begin n_fail++; $display("[TB] FAIL pop1_count got %0d want 7", count_o); end
    n_cmp++; if (wr_ready_o !== 2'b01) begin n_fail++; $display("[TB] FAIL pop1_wr_ready got %b want 01", wr_ready_o); end
    n_cmp++; if (rd_data_o[31:0] !== 32'd1) begin n_fail++; $display("[TB] FAIL pop1_head got %0h want 1", rd_data_o[31:0]); end
    // Only lane 0 fits at count 7: value 8 enters, 0x99 is refused.
    apply_stimulus(1'b0, 2'b11, 32'h99, 32'd8, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd8) begin n_fail++; $display("[TB] FAIL refill_count got %0d want 8", count_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_head;
    logic [31:0] push_val;
    // FIFO holds 1..8 with head at slot 1; streaming wraps slot 7 to slot 0.
    exp_head = 32'd1;
    push_val = 32'd9;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(1'b0, 2'b11, push_val + 32'd1, push_val, 2'b11);
      #1;
      n_cmp++; if (rd_data_o[31:0] !== exp_head) begin n_fail++; $display("[TB] FAIL b2b_lane0[%0d] got %0h want %0h", c, rd_data_o[31:0], exp_head); end
      n_cmp++; if (rd_data_o[63:32] !== exp_head + 32'd1) begin n_fail++; $display("[TB] FAIL b2b_lane1[%0d] got %0h want %0h", c, rd_data_o[63:32], exp_head + 32'd1); end
      if (c == 0) begin
        n_cmp++; if (wr_ready_o !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_full_ready got %b want 00", wr_ready_o); end
      end else begin
        push_val = push_val + 32'd2;
      end
      tick;
      exp_head = exp_head + 32'd2;
      n_cmp++; if (count_o !== 4'd6) begin n_fail++; $display("[TB] FAIL b2b_count[%0d] got %0d want 6", c, count_o); end
    end
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (rd_data_o[31:0] !== 32'd17) begin n_fail++; $display("[TB] FAIL b2b_final_head got %0h want 11", rd_data_o[31:0]); end
  endtask

  task automatic test_noncontiguous;
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b11, 32'h31, 32'h30, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b01, 32'h0, 32'h32, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b10, 32'h77, 32'h0, 2'b00);
    tick;
    n_cmp++; if (count_o !== 4'd3) begin n_fail++; $display("[TB] FAIL gap_push_count got %0d want 3", count_o); end
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd3) begin n_fail++; $display("[TB] FAIL gap_pop_count got %0d want 3", count_o); end
    n_cmp++; if (rd_data_o[31:0] !== 32'h30) begin n_fail++; $display("[TB] FAIL gap_head got %0h want 30", rd_data_o[31:0]); end
    n_cmp++; if (rd_data_o[63:32] !== 32'h31) begin n_fail++; $display("[TB] FAIL gap_lane1 got %0h want 31", rd_data_o[63:32]); end
  endtask

  task automatic test_flush;
    apply_stimulus(1'b0, 2'b11, 32'h34, 32'h33, 2'b00);
    tick;
    n_cmp++; if (count_o !== 4'd5) begin n_fail++; $display("[TB] FAIL preflush_count got %0d want 5", count_o); end
    apply_stimulus(1'b1, 2'b11, 32'h55, 32'h54, 2'b11);
    #1;
    n_cmp++; if (wr_ready_o !== 2'b11) begin n_fail++; $display("[TB] FAIL flushcyc_wr_ready got %b want 11", wr_ready_o); end
    n_cmp++; if (rd_valid_o !== 2'b11) begin n_fail++; $display("[TB] FAIL flushcyc_rd_valid got %b want 11", rd_valid_o); end
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("[TB] FAIL flush_count got %0d want 0", count_o); end
    n_cmp++; if (rd_valid_o !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_rd_valid got %b want 00", rd_valid_o); end
    n_cmp++; if (wr_ready_o !== 2'b11) begin n_fail++; $display("[TB] FAIL flush_wr_ready got %b want 11", wr_ready_o); end
    apply_stimulus(1'b0, 2'b01, 32'h0, 32'hB0, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd1) begin n_fail++; $display("[TB] FAIL postflush_count got %0d want 1", count_o); end
    n_cmp++; if (rd_data_o[31:0] !== 32'hB0) begin n_fail++; $display("[TB] FAIL postflush_data got %0h want b0", rd_data_o[31:0]); end
  endtask

  task automatic test_async_reset;
    apply_stimulus(1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b11, 32'h41, 32'h40, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b11, 32'h43, 32'h42, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd4) begin n_fail++; $display("[TB] FAIL prereset_count got %0d want 4", count_o); end
    #1;
    rst_i = 1'b1;
    #1;
    n_cmp++; if (count_o !== 4'd0) begin n_fail++; $display("[TB] FAIL areset_count got %0d want 0", count_o); end
    n_cmp++; if (rd_valid_o !== 2'b00) begin n_fail++; $display("[TB] FAIL areset_rd_valid got %b want 00", rd_valid_o); end
    n_cmp++; if (wr_ready_o !== 2'b11) begin n_fail++; $display("[TB] FAIL areset_wr_ready got %b want 11", wr_ready_o); end
    #1;
    rst_i = 1'b0;
    apply_stimulus(1'b0, 2'b11, 32'hC1, 32'hC0, 2'b00);
    tick;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    n_cmp++; if (count_o !== 4'd2) begin n_fail++; $display("[TB] FAIL resume_count got %0d want 2", count_o); end
    n_cmp++; if (rd_data_o[31:0] !== 32'hC0) begin n_fail++; $display("[TB] FAIL resume_lane0 got %0h want c0", rd_data_o[31:0]); end
    n_cmp++; if (rd_data_o[63:32] !== 32'hC1) begin n_fail++; $display("[TB] FAIL resume_lane1 got %0h want c1", rd_data_o[63:32]); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_i  = 1'b1;
    apply_stimulus(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    test_reset;
    test_first_push;
    test_fill;
    test_back_to_back;
    test_noncontiguous;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_multi_lane.md
Name: fifo_multi_lane

Overview:
- Parametrised multi-lane FIFO: up to Lanes entries pushed and up to Lanes entries popped per cycle, in strict order.
- Adds over the single-lane FIFO: per-lane handshakes, synchronous flush, occupancy count and almost-full flag.
- Sits between fetch and decode of the superscalar front end as the instruction queue.
- Also serves as a generic wide buffer elsewhere in the core.

Parameters:
- DepthLog2, 3: log2 of slot count; Depth = 2**DepthLog2; must be >= 1.
- Width, 32: bits per entry.
- Lanes, 2: write and read lanes per cycle; 1 <= Lanes <= Depth (elaboration $error otherwise).
- AlmostFullThresh, 6: almost_full_o asserts when count >= this; must satisfy 1 <= AlmostFullThresh <= Depth.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all contents.
- wr_valid_i  in  Lanes  per-lane push request; lane 0 is oldest.
- wr_data_i  in  Lanes*Width  lane k occupies bits [k*Width +: Width].
- wr_ready_o  out  Lanes  lane k may be accepted this cycle.
- rd_valid_o  out  Lanes  lane k holds a valid entry; lane 0 is head.
- rd_data_o  out  Lanes*Width  lane k = entry at head+k.
- rd_ready_i  in  Lanes  per-lane pop acknowledge.
- count_o  out  DepthLog2+1  current occupancy, 0..Depth.
- almost_full_o  out  1  count_o >= AlmostFullThresh.

Behaviour:
- State:
  - rd_ptr, wr_ptr: DepthLog2 bits each, wrap modulo Depth naturally.
  - count: DepthLog2+1 bits.
  - Flop array of Depth x Width.
  - All flops reset asynchronously.
- Reset values: count_o=0, rd_valid_o=0, wr_ready_o=all ones, almost_full_o=0, pointers=0. Storage is not reset.
- Combinational outputs, all from registered count only:
  - wr_ready_o[k] = (Depth - count) > k.
  - rd_valid_o[k] = count > k.
  - almost_full_o = count >= AlmostFullThresh.
  - No input-to-ready/valid combinational path.
- rd_data_o lane k = mem[rd_ptr+k] (first-word fall-through, zero read latency). Data on invalid lanes is don't-care.
- Push acceptance (contiguous prefix rule):
  - Lane k is accepted iff wr_valid_i[0..k] are all 1 and wr_ready_o[k]=1.
  - Valid lanes following a 0 lane are ignored, not written.
  - n_push = number of accepted lanes.
- Pop acceptance uses the same prefix rule on rd_valid_o & rd_ready_i; n_pop = number of popped lanes.
- Update on clock edge (no flush):
  - Accepted lane k writes mem[wr_ptr+k].
  - wr_ptr += n_push; rd_ptr += n_pop; count += n_push - n_pop.
- Write-to-read latency is 1 cycle. A word pushed into an empty FIFO appears on rd lane 0 the next cycle; there is no same-cycle bypass.
- Simultaneous push and pop:
  - Allowed in any state.
  - Free space is judged on start-of-cycle count; slots popped this cycle are not reusable until next cycle.
  - When full, no push is accepted even if a pop occurs.
- Wrap-around: multi-lane writes and reads spanning slot Depth-1 to slot 0 must preserve order.
- Flush:
  - flush_i=1 at an edge sets pointers and count to 0.
  - Pushes and pops presented in that cycle are discarded; flush has priority.
  - Handshake outputs in the flush cycle still reflect pre-flush state.
- Reset mid-operation: outputs take reset values immediately, without waiting for a clock edge. All contents are lost.
- Invariants: count <= Depth; count == (wr_ptr - rd_ptr) mod Depth, except when count == Depth, where the pointers are equal.

Decomposition:
- fifo_pkg holds:
  - function clog2-based count width.
  - function lead_ones_cnt(vector) returning the leading-ones count.
  - Lane-index typedef helpers.
- One natural sub-module: prefix_count, a parametrised leading-ones counter. It is instantiated twice, for push (wr_valid_i & wr_ready_o) and pop (rd_valid_o & rd_ready_i).
- Storage is inline flops; ram_1r1w_sync is not usable (multi-port).

Test Plan:
- Config for all scenarios: DepthLog2=3, Width=32, Lanes=2, AlmostFullThresh=6.
1. Reset, then push valid=11, data {0xA1,0xA0} -> next cycle count_o=2, rd_valid_o=11, lane0=0xA0, lane1=0xA1, almost_full_o=0.
2. Push 11 for 4 consecutive cycles from empty -> count_o 2,4,6,8. almost_full_o=1 from count 6. After full, wr_ready_o=00. At count 7 (pop one), wr_ready_o=01.
3. Full FIFO, pop 11 each cycle while pushing 11 with incrementing data over 8 cycles -> read order strictly incrementing across the slot-7-to-0 wrap; count steady after the first refill cycle.
4. Non-contiguous requests from count 3: wr_valid_i=10 -> count unchanged. rd_ready_i=10 -> nothing popped, head data unchanged.
5. count 5, flush_i=1 together with push 11 and pop 11 -> next cycle count_o=0, rd_valid_o=00, wr_ready_o=11. A subsequent push of 0xB0 reads back 0xB0.
6. Assert rst_i between clock edges at count 4 -> count_o=0, rd_valid_o=00, wr_ready_o=11 before the next edge. Operation resumes normally after deassertion.
